mem_ctrl_arb: RTL and testbench

- Multi-channel byte-serial memory controller with arbitration; successor to the single-client memory controller.
- Sits between N requesters (e.g. instruction fetch, load/store buffer) and the 8-bit RAM/IO bus of the cpu top.
- Serialises 1..DATA_BYTES little-endian reads and writes.
- Arbitrates channels, stalls IO writes on a full UART buffer, freezes on rdy low, and aborts speculative RAM reads on clear.

---
 rtl/mem_ctrl_arb_if.sv | 29 ++
 rtl/mem_ctrl_arb.sv | 165 ++++++++++++++++
 tb/tb_mem_ctrl_arb.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_arb_if.sv
// Request/response and 8-bit memory bus bundle for mem_ctrl_arb.
// slave = controller side, master = requester/memory side.
interface mem_ctrl_arb_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_BYTES = 4,
  parameter int LW         = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
);
  logic [NUM_CH-1:0]              req_valid;
  logic [NUM_CH-1:0]              req_we;
  logic [NUM_CH*32-1:0]           req_addr;
  logic [NUM_CH*LW-1:0]           req_len;
  logic [NUM_CH*8*DATA_BYTES-1:0] req_wdata;
  logic [NUM_CH-1:0]              resp_done;
  logic [8*DATA_BYTES-1:0]        resp_rdata;
  logic [7:0]                     mem_din;
  logic [7:0]                     mem_dout;
  logic [31:0]                    mem_a;
  logic                           mem_wr;

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, mem_din,
    output resp_done, resp_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, mem_din,
    input  resp_done, resp_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Multi-channel byte-serial memory controller with request arbitration.
// Macro MEM_CTRL_RR_EN selects round-robin arbitration; otherwise lowest channel wins.
module mem_ctrl_arb #(
  parameter int NUM_CH     = 2,
  parameter int DATA_BYTES = 4,
  parameter int LW         = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clear,
  input  logic          io_buffer_full,
  mem_ctrl_arb_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = 8 * DATA_BYTES;
  localparam logic [LW:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ch_q;
  logic          io_q;
  logic [LW-1:0] len_q;
  logic [LW:0]   cnt_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [31:0]   mem_a_q;
  logic [7:0]    mem_dout_q;
  logic          mem_wr_q;

  logic [CW-1:0] grant;
  logic          any_req;
  logic          w_we;
  logic          w_io;
  logic [31:0]   w_addr;
  logic [LW-1:0] w_len;
  logic [DW-1:0] w_wdata;
  logic          accept, advance, count, capture;
  logic [LW:0]   len_ext;
  logic [LW:0]   cap_idx;

`ifdef MEM_CTRL_RR_EN
  logic [CW-1:0] ptr_q;

  // Search from ptr_q upward; iterating downward lets the closest hit overwrite.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (bus.req_valid[idx]) begin
        grant   = CW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else if (rdy && accept) ptr_q <= (int'(grant) == NUM_CH - 1) ? '0 : CW'(int'(grant) + 1);
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (bus.req_valid[i]) grant = CW'(i);
  end

  assign any_req = |bus.req_valid;
`endif

  assign w_we    = bus.req_we[grant];
  assign w_addr  = bus.req_addr[32*int'(grant) +: 32];
  assign w_len   = bus.req_len[LW*int'(grant) +: LW];
  assign w_wdata = bus.req_wdata[DW*int'(grant) +: DW];
  assign w_io    = (w_addr[17:16] == 2'b11);
  assign len_ext = {1'b0, len_q};
  assign cap_idx = cnt_q - CNT_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state_q <= IDLE;
    else if (rdy) state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    count   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (any_req && !(clear && !w_we && !w_io)) begin
        accept  = 1'b1;
        state_d = w_we ? WR : RD;
      end
      WR: if (!(io_q && io_buffer_full)) begin
        if (cnt_q == len_ext) state_d = DONE;
        else begin
          advance = 1'b1;
          count   = 1'b1;
        end
      end
      // In RD cnt_q counts bus cycles: address cnt_q is out, byte cnt_q-1 is returning.
      RD: if (clear && !io_q) state_d = IDLE;
      else begin
        count   = 1'b1;
        capture = (cnt_q != '0);
        advance = (cnt_q < len_ext);
        if (cnt_q == len_ext + CNT_ONE) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: rdy low holds every register, so a stalled transfer resumes exactly where it stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q       <= '0;
      io_q       <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else if (rdy) begin
      if (accept) begin
        ch_q       <= grant;
        io_q       <= w_io;
        len_q      <= w_len;
        cnt_q      <= '0;
        wdata_q    <= w_wdata >> 8;
        rdata_q    <= '0;
        mem_a_q    <= w_addr;
        mem_dout_q <= w_wdata[7:0];
        mem_wr_q   <= w_we;
      end else begin
        if (count) cnt_q <= cnt_q + CNT_ONE;
        if (advance) begin
          mem_a_q    <= mem_a_q + 32'd1;
          mem_dout_q <= wdata_q[7:0];
          wdata_q    <= wdata_q >> 8;
        end
        if (capture) rdata_q[8*int'(cap_idx) +: 8] <= bus.mem_din;
        if (state_d != WR) mem_wr_q <= 1'b0;
      end
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.mem_wr     = mem_wr_q && rdy && !(io_q && io_buffer_full);
  assign bus.resp_rdata = rdata_q;

  always_comb begin
    bus.resp_done = '0;
    if (state_q == DONE) bus.resp_done[ch_q] = 1'b1;
  end
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Directed self-checking bench for mem_ctrl_arb; cycle 0 is the cycle a request is raised.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_ctrl_arb;
  localparam int NUM_CH     = 2;
  localparam int DATA_BYTES = 4;
  localparam int LW         = 2;
`ifdef MEM_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rdy, clear, io_buffer_full;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] ram  [0:4095];
  logic [7:0] wmem [0:4095];
  int         wr_count [0:4095];

  mem_ctrl_arb_if #(.NUM_CH(NUM_CH), .DATA_BYTES(DATA_BYTES), .LW(LW)) bus ();

  mem_ctrl_arb #(.NUM_CH(NUM_CH), .DATA_BYTES(DATA_BYTES), .LW(LW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .io_buffer_full(io_buffer_full), .bus(bus)
  );

  always #5 clk = ~clk;

  // Bus memory: read data one cycle after the address, frozen with the system on rdy=0.
  always @(posedge clk) begin
    if (rdy) bus.mem_din <= ram[bus.mem_a[11:0]];
    if (bus.mem_wr) begin
      wmem[bus.mem_a[11:0]]     <= bus.mem_dout;
      wr_count[bus.mem_a[11:0]] <= wr_count[bus.mem_a[11:0]] + 1;
    end
  end

  task automatic set_req(input int ch, input logic we, input logic [31:0] addr,
                         input logic [LW-1:0] len, input logic [31:0] wdata);
    bus.req_we[ch]             = we;
    bus.req_addr[32*ch +: 32]  = addr;
    bus.req_len[LW*ch +: LW]   = len;
    bus.req_wdata[32*ch +: 32] = wdata;
    bus.req_valid[ch]          = 1'b1;
  endtask

  // Runs up to max_cycles falling edges; on the first resp_done drops that request.
  task automatic wait_done(input int max_cycles, input bit drop, output int cyc,
                           output logic [NUM_CH-1:0] who);
    cyc = -1;
    who = '0;
    for (int c = 1; c <= max_cycles && cyc < 0; c++) begin
      @(negedge clk);
      if (bus.resp_done != '0) begin
        cyc = c;
        who = bus.resp_done;
        if (drop) bus.req_valid = bus.req_valid & ~bus.resp_done;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    total++; if (bus.mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout: got %h want 0", bus.mem_dout); end
    total++; if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr); end
    total++; if (bus.resp_done !== 2'b00) begin bad++; $display("FAIL reset_resp_done: got %b want 00", bus.resp_done); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read4();
    logic [31:0] want_a;
    logic [1:0]  want_done;
    set_req(0, 1'b0, 32'h100, 2'd3, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        want_a = 32'h100 + 32'(c - 1);
        total++;
        if (bus.mem_a !== want_a || bus.mem_wr !== 1'b0) begin
          bad++; $display("FAIL read4_addr c%0d: got a=%h wr=%b want a=%h wr=0", c, bus.mem_a, bus.mem_wr, want_a);
        end
      end
      want_done = (c == 6) ? 2'b01 : 2'b00;
      total++;
      if (bus.resp_done !== want_done) begin
        bad++; $display("FAIL read4_done c%0d: got %b want %b", c, bus.resp_done, want_done);
      end
    end
    total++; if (bus.resp_rdata !== 32'h44332211) begin bad++; $display("FAIL read4_data: got %h want 44332211", bus.resp_rdata); end
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write2();
    logic [31:0] exp_a [2] = '{32'h204, 32'h205};
    logic [7:0]  exp_d [2] = '{8'hEF, 8'hBE};
    set_req(1, 1'b1, 32'h204, 2'd1, 32'h0000BEEF);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if (bus.mem_wr !== 1'b1 || bus.mem_a !== exp_a[c-1] || bus.mem_dout !== exp_d[c-1]) begin
        bad++; $display("FAIL write2_bus c%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h",
                        c, bus.mem_wr, bus.mem_a, bus.mem_dout, exp_a[c-1], exp_d[c-1]);
      end
    end
    @(negedge clk);
    total++;
    if (bus.resp_done !== 2'b10 || bus.mem_wr !== 1'b0) begin
      bad++; $display("FAIL write2_done: got done=%b wr=%b want done=10 wr=0", bus.resp_done, bus.mem_wr);
    end
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    total++; if (wmem[12'h204] !== 8'hEF) begin bad++; $display("FAIL write2_ram0: got %h want ef", wmem[12'h204]); end
    total++; if (wmem[12'h205] !== 8'hBE) begin bad++; $display("FAIL write2_ram1: got %h want be", wmem[12'h205]); end
  endtask

  task automatic test_arb();
    int                cyc;
    logic [1:0]        who, exp_who;
    logic [31:0]       exp_rd;
    set_req(0, 1'b0, 32'h100, 2'd0, 32'h0);
    set_req(1, 1'b0, 32'h101, 2'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_done(12, 1'b0, cyc, who);
      exp_who = (RR && (k % 2 == 1)) ? 2'b10 : 2'b01;
      exp_rd  = (exp_who == 2'b01) ? 32'h00000011 : 32'h00000022;
      total++; if (who !== exp_who) begin bad++; $display("FAIL arb_grant k%0d: got %b want %b", k, who, exp_who); end
      total++;
      if (cyc != ((k == 0) ? 3 : 4)) begin
        bad++; $display("FAIL arb_gap k%0d: got %0d want %0d", k, cyc, (k == 0) ? 3 : 4);
      end
      total++; if (bus.resp_rdata !== exp_rd) begin bad++; $display("FAIL arb_data k%0d: got %h want %h", k, bus.resp_rdata, exp_rd); end
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_io_stall();
    io_buffer_full = 1'b1;
    set_req(0, 1'b1, 32'h00030000, 2'd0, 32'h5A);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h00030000) begin
        bad++; $display("FAIL io_stall c%0d: got wr=%b a=%h want wr=0 a=00030000", c, bus.mem_wr, bus.mem_a);
      end
    end
    io_buffer_full = 1'b0;
    #1;
    total++; if (bus.mem_wr !== 1'b1) begin bad++; $display("FAIL io_release: got wr=%b want 1", bus.mem_wr); end
    @(negedge clk);
    total++; if (bus.resp_done !== 2'b01) begin bad++; $display("FAIL io_done: got %b want 01", bus.resp_done); end
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    total++; if (wr_count[0] != 1) begin bad++; $display("FAIL io_once: got %0d writes want 1", wr_count[0]); end
    total++; if (wmem[0] !== 8'h5A) begin bad++; $display("FAIL io_data: got %h want 5a", wmem[0]); end
  endtask

  task automatic test_pause();
    int          cyc;
    logic [31:0] wd = 32'hA1B2C3D4;
    logic [7:0]  exp_b;
    set_req(0, 1'b0, 32'h100, 2'd3, 32'h0);
    cyc = -1;
    for (int c = 1; c <= 14 && cyc < 0; c++) begin
      @(negedge clk);
      if (c == 2) rdy = 1'b0;
      if (c == 5) rdy = 1'b1;
      if (bus.resp_done != '0) begin cyc = c; bus.req_valid[0] = 1'b0; end
    end
    total++; if (cyc != 9) begin bad++; $display("FAIL pause_rd_cycle: got %0d want 9", cyc); end
    total++; if (bus.resp_rdata !== 32'h44332211) begin bad++; $display("FAIL pause_rd_data: got %h want 44332211", bus.resp_rdata); end
    @(negedge clk);

    set_req(1, 1'b1, 32'h208, 2'd3, wd);
    cyc = -1;
    for (int c = 1; c <= 14 && cyc < 0; c++) begin
      @(negedge clk);
      if (c == 2) begin rdy = 1'b0; #1; end
      if (c >= 2 && c <= 4) begin
        total++; if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL pause_wr_gate c%0d: got %b want 0", c, bus.mem_wr); end
      end
      if (c == 5) rdy = 1'b1;
      if (bus.resp_done != '0) begin cyc = c; bus.req_valid[1] = 1'b0; end
    end
    total++; if (cyc != 8) begin bad++; $display("FAIL pause_wr_cycle: got %0d want 8", cyc); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_b = wd[8*i +: 8];
      total++;
      if (wr_count[12'h208 + i] != 1 || wmem[12'h208 + i] !== exp_b) begin
        bad++; $display("FAIL pause_wr_byte%0d: got n=%0d d=%h want n=1 d=%h", i, wr_count[12'h208 + i], wmem[12'h208 + i], exp_b);
      end
    end
  endtask

  task automatic test_clear();
    int         cyc;
    logic [1:0] who;
    // RAM read aborted in cycle 2; the still-held request restarts from IDLE in cycle 3.
    set_req(0, 1'b0, 32'h100, 2'd3, 32'h0);
    cyc = -1;
    for (int c = 1; c <= 14 && cyc < 0; c++) begin
      @(negedge clk);
      if (c == 2) clear = 1'b1;
      if (c == 3) clear = 1'b0;
      if (bus.resp_done != '0) begin cyc = c; bus.req_valid[0] = 1'b0; end
    end
    total++; if (cyc != 9) begin bad++; $display("FAIL clear_ram_cycle: got %0d want 9", cyc); end
    total++; if (bus.resp_rdata !== 32'h44332211) begin bad++; $display("FAIL clear_ram_data: got %h want 44332211", bus.resp_rdata); end
    @(negedge clk);

    set_req(0, 1'b0, 32'h00030000, 2'd0, 32'h0);
    cyc = -1;
    for (int c = 1; c <= 10 && cyc < 0; c++) begin
      @(negedge clk);
      if (c == 2) clear = 1'b1;
      if (c == 3) clear = 1'b0;
      if (bus.resp_done != '0) begin cyc = c; bus.req_valid[0] = 1'b0; end
    end
    clear = 1'b0;
    total++; if (cyc != 3) begin bad++; $display("FAIL clear_io_cycle: got %0d want 3", cyc); end
    total++; if (bus.resp_rdata !== 32'h00000077) begin bad++; $display("FAIL clear_io_data: got %h want 00000077", bus.resp_rdata); end
    @(negedge clk);

    clear = 1'b1;
    set_req(0, 1'b0, 32'h101, 2'd0, 32'h0);
    @(negedge clk);
    clear = 1'b0;
    wait_done(10, 1'b1, cyc, who);
    total++; if (cyc != 3 || who !== 2'b01) begin bad++; $display("FAIL clear_idle_block: got cycle=%0d done=%b want cycle=4 done=01", cyc + 1, who); end
    total++; if (bus.resp_rdata !== 32'h00000022) begin bad++; $display("FAIL clear_idle_data: got %h want 00000022", bus.resp_rdata); end
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b0;
    rdy            = 1'b1;
    clear          = 1'b0;
    io_buffer_full = 1'b0;
    bus.req_valid  = '0;
    bus.req_we     = '0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11;
    ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33;
    ram[12'h103] = 8'h44;
    ram[12'h000] = 8'h77;

    test_reset();
    test_read4();
    test_write2();
    test_arb();
    test_io_stall();
    test_pause();
    test_clear();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
